// File: rtl/mfcc_melbank_coef_streamer_if.sv
// Burst-request and coefficient-stream bundle for the mel-filterbank coefficient streamer.
// The master is the client that requests bursts and consumes beats; the slave is the streamer.
interface mfcc_melbank_coef_streamer_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BANK_WIDTH = 3
);
    logic                  start;
    logic [BANK_WIDTH-1:0] bank_sel;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  done;
    logic                  err;

    modport master (
        output start, bank_sel, base_addr, length, out_ready,
        input  busy, out_valid, out_data, out_last, done, err
    );

    modport slave (
        input  start, bank_sel, base_addr, length, out_ready,
        output busy, out_valid, out_data, out_last, done, err
    );
endinterface

// File: rtl/mfcc_melbank_coef_streamer.sv
// Shared multi-bank mel-filterbank coefficient ROM with a burst-read engine that streams
// consecutive words from one bank onto a registered valid/ready output.
module mfcc_melbank_coef_streamer #(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned BANK_WIDTH  = 3,
    parameter int unsigned NUM_BANKS   = 8,
    parameter string       INIT_FILE   = "NONE",
    parameter string       FILE_FORMAT = "BIN"
) (
    input logic                         clk,
    input logic                         rst,
    mfcc_melbank_coef_streamer_if.slave bus
);
    localparam int unsigned Words    = 2 ** ADDR_WIDTH;
    localparam int unsigned MemDepth = NUM_BANKS * Words;
    localparam int unsigned MemIdxW  = $clog2(MemDepth);

    localparam logic [BANK_WIDTH:0] NumBanksW = (BANK_WIDTH + 1)'(NUM_BANKS);
    localparam logic [ADDR_WIDTH:0] MaxLen    = (ADDR_WIDTH + 1)'(Words);
    localparam logic [ADDR_WIDTH:0] LenOne    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    state_e                state_q;
    logic [BANK_WIDTH-1:0] bank_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic                  busy_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  done_q;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] mem [MemDepth];

    logic [ADDR_WIDTH:0]   len_eff;
    logic                  bank_ok;
    logic [BANK_WIDTH-1:0] rd_bank;
    logic [ADDR_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_data;

    initial begin
        for (int unsigned i = 0; i < MemDepth; i++) mem[i] = '0;
    end

    always_comb begin
        len_eff = (bus.length > MaxLen) ? MaxLen : bus.length;
        bank_ok = ({1'b0, bus.bank_sel} < NumBanksW);
        rd_bank = bank_q;
        rd_word = rd_addr_q;
        // In idle the first word is fetched straight from the request so it lands next cycle.
        if (state_q == StIdle) begin
            rd_bank = bus.bank_sel;
            rd_word = bus.base_addr;
        end
    end

    // Bank in the upper index bits keeps the wrapping word address inside its own bank.
    assign rd_data = mem[MemIdxW'({rd_bank, rd_word})];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bank_q      <= '0;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start && (len_eff != '0)) begin
                        if (!bank_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            bank_q      <= bus.bank_sel;
                            out_data_q  <= rd_data;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (len_eff == LenOne);
                            rd_addr_q   <= bus.base_addr + AddrOne;
                            remaining_q <= len_eff - LenOne;
                            busy_q      <= 1'b1;
                            state_q     <= (len_eff == LenOne) ? StDrain : StStream;
                        end
                    end
                end
                StStream: begin
                    if (!out_valid_q || bus.out_ready) begin
                        out_data_q  <= rd_data;
                        out_valid_q <= 1'b1;
                        rd_addr_q   <= rd_addr_q + AddrOne;
                        remaining_q <= remaining_q - LenOne;
                        if (remaining_q == LenOne) begin
                            out_last_q <= 1'b1;
                            state_q    <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
